// File: rtl/aes_sched_pkg.sv
// Shared types and constants for the AES byte scheduler: FSM state encoding,
// block geometry, counter width and the {valid,last} tag carried alongside issued bytes.
package aes_sched_pkg;

  localparam int BLOCK_BYTES = 16;
  localparam int CNT_W       = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FILL  = 2'd1,
    ST_ISSUE = 2'd2
  } sched_state_e;

  typedef logic [CNT_W-1:0] byte_idx_t;

  typedef struct packed {
    logic valid;
    logic last;
  } tag_t;

  localparam byte_idx_t LAST_IDX = byte_idx_t'(BLOCK_BYTES - 1);

  // True when idx addresses the final byte of a block.
  function automatic logic is_last_idx(input byte_idx_t idx);
    return idx == LAST_IDX;
  endfunction

endpackage

// File: rtl/aes_byte_scheduler_if.sv
// Byte-stream bus of the AES byte scheduler: input stream, datapath side and processed output.
// The slave modport is the scheduler; the master modport is the surrounding system.
interface aes_byte_scheduler_if;

  logic       in_valid;
  logic [7:0] in_byte;
  logic       in_flush;
  logic       in_ready;

  logic       dp_sync;
  logic       dp_valid;
  logic [7:0] dp_byte;
  logic [7:0] dp_result;

  logic       out_valid;
  logic [7:0] out_byte;
  logic       out_last;

  modport slave (
    input  in_valid, in_byte, in_flush, dp_result,
    output in_ready, dp_sync, dp_valid, dp_byte, out_valid, out_byte, out_last
  );

  modport master (
    output in_valid, in_byte, in_flush, dp_result,
    input  in_ready, dp_sync, dp_valid, dp_byte, out_valid, out_byte, out_last
  );

endinterface

// File: rtl/tag_delay_line.sv
// Fixed-depth shift register that carries per-byte {valid,last} tags in step with
// the external datapath latency; cleared by the asynchronous active-low reset.
module tag_delay_line #(
  parameter int DEPTH = 12,
  parameter int WIDTH = 2
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] tag_in,
  output logic [WIDTH-1:0] tag_out
);

  logic [WIDTH-1:0] stage_reg [DEPTH];

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        stage_reg[i] <= '0;
      end
    end else begin
      stage_reg[0] <= tag_in;
      for (int i = 1; i < DEPTH; i++) begin
        stage_reg[i] <= stage_reg[i-1];
      end
    end
  end

  assign tag_out = stage_reg[DEPTH-1];

endmodule

// File: rtl/aes_byte_scheduler.sv
// Collects 16-byte AES state blocks and issues each one contiguously to a fixed-latency
// byte-serial datapath. Optional macro SCHED_STATS_EN adds a 16-bit completed-block counter.
module aes_byte_scheduler #(
  parameter int LATENCY     = 12,
  parameter int BLOCK_BYTES = aes_sched_pkg::BLOCK_BYTES
) (
  input  logic                clock,
  input  logic                reset_n,
  aes_byte_scheduler_if.slave bus
`ifdef SCHED_STATS_EN
  ,
  output logic [15:0]         blk_count
`endif
);

  import aes_sched_pkg::*;

  sched_state_e state_reg, state_next;
  byte_idx_t    fill_cnt_reg, fill_cnt_next;
  byte_idx_t    issue_cnt_reg, issue_cnt_next;
  logic         accept;
  tag_t         tag_in;
  tag_t         tag_out;

  logic [7:0]   blk_buf [BLOCK_BYTES];

  logic         out_valid_reg;
  logic         out_last_reg;
  logic [7:0]   out_byte_reg;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_reg     <= ST_IDLE;
      fill_cnt_reg  <= '0;
      issue_cnt_reg <= '0;
    end else begin
      state_reg     <= state_next;
      fill_cnt_reg  <= fill_cnt_next;
      issue_cnt_reg <= issue_cnt_next;
    end
  end

  // Flush only has meaning while filling, and it takes priority over a coincident byte.
  always_comb begin
    state_next     = state_reg;
    fill_cnt_next  = fill_cnt_reg;
    issue_cnt_next = issue_cnt_reg;
    accept         = 1'b0;
    tag_in         = '0;
    bus.in_ready   = 1'b0;
    bus.dp_valid   = 1'b0;
    bus.dp_sync    = 1'b0;
    bus.dp_byte    = 8'h00;

    unique case (state_reg)
      ST_IDLE: begin
        state_next = ST_FILL;
      end

      ST_FILL: begin
        bus.in_ready = 1'b1;
        if (bus.in_flush) begin
          fill_cnt_next = '0;
        end else if (bus.in_valid) begin
          accept = 1'b1;
          if (is_last_idx(fill_cnt_reg)) begin
            fill_cnt_next = '0;
            state_next    = ST_ISSUE;
          end else begin
            fill_cnt_next = fill_cnt_reg + 1'b1;
          end
        end
      end

      ST_ISSUE: begin
        bus.dp_valid = 1'b1;
        bus.dp_sync  = (issue_cnt_reg == '0);
        bus.dp_byte  = blk_buf[issue_cnt_reg];
        tag_in.valid = 1'b1;
        tag_in.last  = is_last_idx(issue_cnt_reg);
        if (is_last_idx(issue_cnt_reg)) begin
          issue_cnt_next = '0;
          state_next     = ST_FILL;
        end else begin
          issue_cnt_next = issue_cnt_reg + 1'b1;
        end
      end

      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // Block buffer holds no reset value; fill_cnt alone decides what is meaningful.
  always_ff @(posedge clock) begin
    if (accept) begin
      blk_buf[fill_cnt_reg] <= bus.in_byte;
    end
  end

  tag_delay_line #(
    .DEPTH (LATENCY),
    .WIDTH (2)
  ) u_tag_delay (
    .clock   (clock),
    .reset_n (reset_n),
    .tag_in  (tag_in),
    .tag_out (tag_out)
  );

  // The tag reaches the pipe output in the same cycle the datapath presents its result.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      out_valid_reg <= 1'b0;
      out_last_reg  <= 1'b0;
      out_byte_reg  <= 8'h00;
    end else begin
      out_valid_reg <= tag_out.valid;
      out_last_reg  <= tag_out.valid & tag_out.last;
      out_byte_reg  <= tag_out.valid ? bus.dp_result : 8'h00;
    end
  end

  assign bus.out_valid = out_valid_reg;
  assign bus.out_last  = out_last_reg;
  assign bus.out_byte  = out_byte_reg;

`ifdef SCHED_STATS_EN
  logic [15:0] blk_count_reg;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      blk_count_reg <= 16'd0;
    end else if (out_last_reg) begin
      blk_count_reg <= blk_count_reg + 16'd1;
    end
  end

  assign blk_count = blk_count_reg;
`endif

endmodule

// File: tb/tb_aes_byte_scheduler.sv
// Self-checking bench for aes_byte_scheduler: queue-based block model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic with a mid-run reset.
module tb_aes_byte_scheduler;

  localparam int LAT = 12;

  logic clock   = 1'b0;
  logic reset_n = 1'b0;

  aes_byte_scheduler_if bus ();

`ifdef SCHED_STATS_EN
  logic [15:0] blk_count;
`endif

  aes_byte_scheduler #(
    .LATENCY     (LAT),
    .BLOCK_BYTES (16)
  ) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
`ifdef SCHED_STATS_EN
    ,
    .blk_count (blk_count)
`endif
  );

  always #5 clock = ~clock;

  // Loopback datapath: dp_result is dp_byte delayed by LAT cycles.
  logic [7:0] dly [LAT];
  always @(posedge clock) begin
    dly[0] <= bus.dp_byte;
    for (int i = 1; i < LAT; i++) dly[i] <= dly[i-1];
  end
  assign bus.dp_result = dly[LAT-1];

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d actual=0x%0h required=0x%0h", name, cyc, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  bit         m_idle = 1'b1;
  logic [7:0] fillq  [$];
  logic [7:0] issueq [$];
  logic [8:0] pend   [int];
  int         blk_model = 0;

  logic [7:0] seen_dp  [$];
  logic [8:0] seen_out [$];
  int dp_first = -1, dp_last = -1, out_first = -1;

  initial begin : compare_proc
    logic [7:0] b;
    logic       e_ov, e_ol;
    logic [7:0] e_ob;
    forever begin
      @(posedge clock);
      #1;
      cyc++;
      if (!reset_n) begin
        m_idle = 1'b1;
        fillq.delete();
        issueq.delete();
        pend.delete();
        blk_model = 0;
      end else if (m_idle) begin
        m_idle = 1'b0;
      end else if (issueq.size() != 0) begin
        b = issueq.pop_front();
        pend[cyc + LAT] = {issueq.size() == 0, b};
      end else if (bus.in_flush) begin
        fillq.delete();
      end else if (bus.in_valid) begin
        fillq.push_back(bus.in_byte);
        if (fillq.size() == 16) begin
          issueq = fillq;
          fillq.delete();
        end
      end

      e_ov = 1'b0; e_ol = 1'b0; e_ob = 8'h00;
      if (pend.exists(cyc)) begin
        e_ov = 1'b1;
        e_ol = pend[cyc][8];
        e_ob = pend[cyc][7:0];
        pend.delete(cyc);
      end

      chk("in_ready",  32'(bus.in_ready), 32'(!m_idle && issueq.size() == 0));
      chk("dp_valid",  32'(bus.dp_valid), 32'(issueq.size() != 0));
      chk("dp_sync",   32'(bus.dp_sync),  32'(issueq.size() == 16));
      chk("dp_byte",   32'(bus.dp_byte),  (issueq.size() != 0) ? 32'(issueq[0]) : 32'd0);
      chk("out_valid", 32'(bus.out_valid), 32'(e_ov));
      chk("out_last",  32'(bus.out_last),  32'(e_ol));
      if (e_ov) chk("out_byte", 32'(bus.out_byte), 32'(e_ob));
`ifdef SCHED_STATS_EN
      chk("blk_count", 32'(blk_count), 32'(blk_model[15:0]));
      if (e_ol) blk_model++;
`endif

      if (bus.dp_valid) begin
        if (dp_first < 0) dp_first = cyc;
        dp_last = cyc;
        seen_dp.push_back(bus.dp_byte);
      end
      if (bus.out_valid) begin
        if (out_first < 0) out_first = cyc;
        seen_out.push_back({bus.out_last, bus.out_byte});
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  int acc_first = 0, acc_last = 0;

  task automatic clear_seen();
    seen_dp.delete();
    seen_out.delete();
    dp_first  = -1;
    dp_last   = -1;
    out_first = -1;
  endtask

  task automatic feed(input logic [7:0] first, input int n, input bit toggle);
    for (int i = 0; i < n; i++) begin
      bus.in_valid = 1'b1;
      bus.in_byte  = 8'(first + 8'(i));
      @(negedge clock);
      if (i == 0) acc_first = cyc;
      acc_last = cyc;
      if (toggle) begin
        bus.in_valid = 1'b0;
        bus.in_byte  = 8'hFF;
        @(negedge clock);
      end
    end
    bus.in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic check_block(input string tag, input logic [7:0] first, input bit with_out);
    chk({tag, "_dp_count"}, 32'(seen_dp.size()), 32'd16);
    chk({tag, "_dp_span"},  32'(dp_last - dp_first), 32'd15);
    for (int i = 0; i < 16; i++) begin
      chk({tag, "_dp_data"}, 32'(seen_dp[i]), 32'(8'(first + 8'(i))));
    end
    if (with_out) begin
      chk({tag, "_out_count"}, 32'(seen_out.size()), 32'd16);
      chk({tag, "_out_lat"},   32'(out_first - dp_first), 32'(LAT + 1));
      for (int i = 0; i < 16; i++) begin
        chk({tag, "_out_data"}, 32'(seen_out[i][7:0]), 32'(8'(first + 8'(i))));
        chk({tag, "_out_last"}, 32'(seen_out[i][8]), 32'(i == 15));
      end
    end
  endtask

  task automatic do_reset(input int n);
    reset_n = 1'b0;
    idle(n);
    reset_n = 1'b1;
    @(negedge clock);
  endtask

  // ---------------- directed + random stimulus ----------------
  initial begin : stim_proc
    bit found;
    bus.in_valid = 1'b0;
    bus.in_byte  = 8'h00;
    bus.in_flush = 1'b0;

    // Reset state
    idle(3);
    chk("rst_in_ready",  32'(bus.in_ready), 32'd0);
    chk("rst_dp_valid",  32'(bus.dp_valid), 32'd0);
    chk("rst_dp_byte",   32'(bus.dp_byte), 32'd0);
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_out_byte",  32'(bus.out_byte), 32'd0);
    reset_n = 1'b1;
    @(negedge clock);
    chk("fill_in_ready", 32'(bus.in_ready), 32'd1);

    // Basic block 0x00..0x0F with loopback
    clear_seen();
    feed(8'h00, 16, 1'b0);
    chk("basic_dp_start", 32'(dp_first), 32'(acc_last));
    chk("basic_sync",     32'(bus.dp_sync), 32'd1);
    chk("basic_first",    32'(bus.dp_byte), 32'h00);
    idle(40);
    check_block("basic", 8'h00, 1'b1);

    // Partial fill then flush (flush wins over a coincident byte)
    clear_seen();
    feed(8'h10, 7, 1'b0);
    bus.in_valid = 1'b1;
    bus.in_byte  = 8'hEE;
    bus.in_flush = 1'b1;
    @(negedge clock);
    bus.in_flush = 1'b0;
    feed(8'hA0, 16, 1'b0);
    idle(40);
    check_block("flush", 8'hA0, 1'b1);

    // Sparse input: fill spans 32 cycles, issue still contiguous
    clear_seen();
    feed(8'h30, 16, 1'b1);
    chk("toggle_fill_span", 32'(acc_last - acc_first), 32'd30);
    idle(40);
    check_block("toggle", 8'h30, 1'b1);

    // Reset at issue byte 8 abandons the block
    clear_seen();
    feed(8'h50, 16, 1'b0);
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      if (bus.dp_valid && bus.dp_byte == 8'h58) found = 1'b1;
      else @(negedge clock);
    end
    chk("abort_reached_byte8", 32'(found), 32'd1);
    reset_n = 1'b0;
    #1;
    chk("abort_dp_valid",  32'(bus.dp_valid), 32'd0);
    chk("abort_dp_byte",   32'(bus.dp_byte), 32'd0);
    chk("abort_dp_sync",   32'(bus.dp_sync), 32'd0);
    chk("abort_in_ready",  32'(bus.in_ready), 32'd0);
    chk("abort_out_valid", 32'(bus.out_valid), 32'd0);
    idle(2);
    reset_n = 1'b1;
    @(negedge clock);
    idle(30);
    chk("abort_no_out", 32'(seen_out.size()), 32'd0);
    clear_seen();
    feed(8'h60, 16, 1'b0);
    idle(40);
    check_block("after_abort", 8'h60, 1'b1);

    // Randomized traffic with one reset in the middle
    for (int i = 0; i < 600; i++) begin
      bus.in_valid = ($urandom_range(0, 9) < 7);
      bus.in_byte  = 8'($urandom);
      bus.in_flush = ($urandom_range(0, 39) == 0);
      if (i == 300) reset_n = 1'b0;
      if (i == 302) reset_n = 1'b1;
      @(negedge clock);
    end
    bus.in_valid = 1'b0;
    bus.in_flush = 1'b0;
    idle(40);

`ifdef SCHED_STATS_EN
    // Three back-to-back blocks counted from a fresh reset
    do_reset(2);
    for (int k = 0; k < 3; k++) begin
      feed(8'(8'h80 + 8'(k * 16)), 16, 1'b0);
      idle(16);
    end
    idle(30);
    chk("stats_three_blocks", 32'(blk_count), 32'd3);
`else
    do_reset(2);
    clear_seen();
    feed(8'hC0, 16, 1'b0);
    idle(40);
    check_block("final", 8'hC0, 1'b1);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/aes_byte_scheduler.md
AES_BYTE_SCHEDULER -- requirements
Module: aes_byte_scheduler

Interface
REQ-001 Parameter: LATENCY, default 12, fixed clock cycles from dp_byte sample to the matching dp_result byte in the downstream byte-serial datapath; legal range 1..31.
REQ-002 Parameter: BLOCK_BYTES, default 16, bytes per AES state block; fixed at 16.
REQ-003 Port: clock  input  1  single system clock; all state changes on its rising edge.
REQ-004 Port: reset_n  input  1  asynchronous, active-low reset.
REQ-005 Port: in_valid  input  1  in_byte holds a valid state byte.
REQ-006 Port: in_byte  input  8  input state byte, column-major order, byte 0 first.
REQ-007 Port: in_flush  input  1  discard any partially collected block.
REQ-008 Port: in_ready  output  1  scheduler accepts in_byte this cycle.
REQ-009 Port: dp_sync  output  1  one-cycle pulse coincident with byte 0 of an issued block.
REQ-010 Port: dp_valid  output  1  dp_byte holds an issued byte.
REQ-011 Port: dp_byte  output  8  byte driven to the datapath.
REQ-012 Port: dp_result  input  8  datapath output byte.
REQ-013 Port: out_valid  output  1  out_byte holds a processed byte.
REQ-014 Port: out_byte  output  8  processed byte, registered copy of dp_result.
REQ-015 Port: out_last  output  1  out_byte is byte 15 of its block.

Function
REQ-016 The FSM SHALL have states IDLE, FILL, ISSUE; IDLE->FILL on the first cycle after reset release; FILL->ISSUE when byte 15 is accepted; ISSUE->FILL after byte 15 is issued.
REQ-017 A byte is accepted only when in_valid && in_ready; accepted bytes SHALL be stored in a 16x8 buffer at index fill_cnt, and fill_cnt SHALL increment from 0 to 15.
REQ-018 in_ready SHALL be 1 in FILL and 0 in IDLE and ISSUE; no input byte is accepted during ISSUE.
REQ-019 In ISSUE, the block SHALL issue buf[0..15] on 16 consecutive cycles with dp_valid=1, without bubbles; dp_sync=1 only with buf[0].
REQ-020 Outside ISSUE, dp_valid=0, dp_sync=0 and dp_byte=0.
REQ-021 A LATENCY-deep tag shift register SHALL carry {valid,last} from issue; out_valid/out_last SHALL assert exactly LATENCY+1 cycles after the corresponding dp_valid/last issue cycle, and out_byte SHALL be dp_result registered in that cycle.
REQ-022 Minimum block period is 32 cycles (16 fill + 16 issue); consecutive blocks SHALL not overlap at dp_byte.
REQ-023 in_flush in FILL SHALL clear fill_cnt to 0 and discard the buffered bytes; an in_valid byte in the same cycle is dropped (flush wins).
REQ-024 in_flush in ISSUE or IDLE SHALL be ignored; in-flight tags are never cleared by flush.
REQ-025 fill_cnt and issue_cnt are 4-bit, wrap 15->0 only on a state transition, and never otherwise.

Reset
REQ-026 While reset_n=0: state=IDLE, counters=0, tag pipe cleared, in_ready=0, dp_valid=0, dp_sync=0, dp_byte=0, out_valid=0, out_last=0, out_byte=0.
REQ-027 Reset mid-ISSUE or mid-FILL SHALL abandon the block; no out_valid for its in-flight bytes after reset release.
REQ-028 The buffer contents need no reset value.

Configuration
REQ-029 Macro SCHED_STATS_EN: when defined, add output blk_count (16-bit, wraps at 65535->0), incremented on each out_last=1 and reset to 0; when undefined, the port and logic SHALL be absent.

Structure
REQ-030 Shared package aes_sched_pkg holds the state encoding (IDLE=0, FILL=1, ISSUE=2), BLOCK_BYTES=16 and the counter width of 4.
REQ-031 The tag delay SHALL be a sub-module tag_delay_line (parameter DEPTH=LATENCY, width 2, async active-low reset).

Verification
REQ-032 Reset, then 16 bytes 0x00..0x0F with in_valid held -> dp_valid for 16 cycles starting the cycle after byte 15, dp_sync with 0x00, dp_byte 0x00..0x0F in order.
REQ-033 Loopback datapath (dp_result = dp_byte delayed 12) -> out_valid 13 cycles after each issue; out_byte 0x00..0x0F; out_last with 0x0F only.
REQ-034 Feed 7 bytes, assert in_flush, feed 16 bytes 0xA0..0xAF -> issued block is 0xA0..0xAF; the first 7 bytes never appear.
REQ-035 in_valid toggled 1/0 every cycle -> fill takes 32 cycles; the block is still issued contiguously for 16 cycles.
REQ-036 Pulse reset_n low at issue byte 8 -> all outputs 0 immediately; no out_valid for the abandoned block; the next 16 bytes are processed normally.
REQ-037 With SCHED_STATS_EN, 3 back-to-back blocks -> blk_count = 3 after the third out_last.
